// File: rtl/riscv_lsu_pkg.sv
// Shared LSU definitions: access-size encodings, FSM states and lane helpers.
// Used by riscv_lsu and by the decoder.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_BUSY,
    LSU_DONE
  } lsu_state_e;

  function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      LDST_B, LDST_BU: lsu_be = 4'b0001 << addr_lo;
      LDST_H, LDST_HU: lsu_be = 4'b0011 << {addr_lo[1], 1'b0};
      default:         lsu_be = '1;
    endcase
  endfunction

  function automatic logic [31:0] lsu_wd(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      LDST_B, LDST_BU: lsu_wd = {4{wd[7:0]}};
      LDST_H, LDST_HU: lsu_wd = {2{wd[15:0]}};
      default:         lsu_wd = wd;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      LDST_B, LDST_BU: lsu_misaligned = 1'b0;
      LDST_H, LDST_HU: lsu_misaligned = addr_lo[0];
      default:         lsu_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_rdata_ext.sv
// Load-data lane select and sign/zero extension; sizes other than B/BU/H/HU
// pass the word through.
module lsu_rdata_ext
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      LDST_B:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: rdata_o = {24'b0, byte_sel};
      LDST_H:  rdata_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: rdata_o = {16'b0, half_sel};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: registers a core request, drives one memory access and
// stalls the core until it completes. Optional macro: LSU_MISALIGN_CHECK_EN.
module riscv_lsu
  import riscv_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_e  state_q;
  logic [2:0]  size_q;
  logic [31:0] rd_q;
  logic [31:0] rd_ext;

  lsu_rdata_ext u_rdata_ext (
    .size_i    (size_q),
    .addr_lo_i (mem_addr_o[1:0]),
    .rdata_i   (mem_rd_i),
    .rdata_o   (rd_ext)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign_q;
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign core_rd_o = rd_q;

  always_comb begin
    core_stall_o = 1'b0;
    case (state_q)
      LSU_IDLE: core_stall_o = core_req_i;
      LSU_BUSY: core_stall_o = 1'b1;
      default:  core_stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LSU_IDLE;
      size_q     <= '0;
      rd_q       <= '0;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_be_o   <= '0;
      mem_addr_o <= '0;
      mem_wd_o   <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (core_req_i) begin
            mem_we_o   <= core_we_i;
            size_q     <= core_size_i;
            mem_addr_o <= core_addr_i;
            mem_be_o   <= lsu_be(core_size_i, core_addr_i[1:0]);
            mem_wd_o   <= lsu_wd(core_size_i, core_wd_i);
`ifdef LSU_MISALIGN_CHECK_EN
            // Misaligned accesses never reach memory; they report through DONE.
            if (lsu_misaligned(core_size_i, core_addr_i[1:0])) begin
              rd_q       <= '0;
              misalign_q <= 1'b1;
              state_q    <= LSU_DONE;
            end else begin
              mem_req_o <= 1'b1;
              state_q   <= LSU_BUSY;
            end
`else
            mem_req_o <= 1'b1;
            state_q   <= LSU_BUSY;
`endif
          end
        end
        LSU_BUSY: begin
          if (mem_ready_i) begin
            if (!mem_we_o) rd_q <= rd_ext;
            mem_req_o <= 1'b0;
            state_q   <= LSU_DONE;
          end
        end
        LSU_DONE: begin
`ifdef LSU_MISALIGN_CHECK_EN
          misalign_q <= 1'b0;
`endif
          state_q <= LSU_IDLE;
        end
        default: begin
          mem_req_o <= 1'b0;
          state_q   <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed vector table, hand-written corner
// sequences and randomized accesses against a byte-lane reference model.
module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o, misalign_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [31:0] last_rd;

  riscv_lsu dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .misalign_o   (misalign_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: access width in bytes, natural lane offset, byte-wise lanes.
  function automatic int unsigned m_bytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int unsigned m_off(input logic [2:0] sz, input logic [31:0] addr);
    int unsigned n = m_bytes(sz);
    return ((addr % 4) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] addr);
    logic [3:0] be = '0;
    for (int unsigned i = 0; i < m_bytes(sz); i++) be[m_off(sz, addr) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] r = '0;
    for (int unsigned i = 0; i < 4; i++)
      r = r | (((wd >> (8 * (i % m_bytes(sz)))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] mrd);
    longint unsigned mask, val;
    int unsigned n = m_bytes(sz);
    mask = (64'd1 << (8 * n)) - 1;
    val  = (longint'(mrd) >> (8 * m_off(sz, addr))) & mask;
    if ((sz == 3'd0 || sz == 3'd1) && val[8*n-1]) val = val | ~mask;
    return val[31:0];
  endfunction

  // One full access; returns at the start of the IDLE cycle after DONE, core_req_i still high.
  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] mrd, input int unsigned delay,
                        input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
    int unsigned busy = 0;
    core_req_i = 1'b1; core_we_i = we; core_size_i = sz; core_addr_i = addr; core_wd_i = wd;
    #1 chk("idle_stall", {31'b0, core_stall_o}, 32'd1);
    @(posedge clk_i); #1;
    while (core_stall_o && busy < 20) begin
      chk("busy_req",  {31'b0, mem_req_o}, 32'd1);
      chk("busy_we",   {31'b0, mem_we_o}, {31'b0, we});
      chk("busy_be",   {28'b0, mem_be_o}, {28'b0, ebe});
      chk("busy_addr", mem_addr_o, addr);
      chk("busy_wd",   mem_wd_o, ewd);
      // Core inputs change under the registered request to prove they were captured.
      core_addr_i = $urandom; core_wd_i = $urandom;
      mem_ready_i = (busy == delay);
      mem_rd_i    = (busy == delay) ? mrd : $urandom;
      @(posedge clk_i); #1;
      mem_ready_i = 1'b0;
      busy++;
    end
    chk("busy_cycles", busy, delay + 1);
    chk("done_req", {31'b0, mem_req_o}, 32'd0);
    chk("done_rd", core_rd_o, erd);
    chk("done_misalign", {31'b0, misalign_o}, 32'd0);
    @(posedge clk_i); #1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    int unsigned delay;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 3'd0, 32'h13, 32'h000000A5, 32'h0,        0, 4'b1000, 32'hA5A5A5A5, 32'h0};
    vecs[2] = '{1'b0, 3'd0, 32'h01, 32'h0,        32'h00008000, 0, 4'b0010, 32'h0, 32'hFFFFFF80};
    vecs[3] = '{1'b0, 3'd4, 32'h01, 32'h0,        32'h00008000, 1, 4'b0010, 32'h0, 32'h00000080};
    vecs[4] = '{1'b0, 3'd1, 32'h02, 32'h0,        32'h80010000, 0, 4'b1100, 32'h0, 32'hFFFF8001};
    vecs[5] = '{1'b0, 3'd2, 32'h20, 32'h0,        32'h12345678, 3, 4'b1111, 32'h0, 32'h12345678};
    vecs[6] = '{1'b0, 3'd5, 32'h00, 32'h0,        32'hABCDFFFF, 2, 4'b0011, 32'h0, 32'h0000FFFF};
    vecs[7] = '{1'b1, 3'd1, 32'h02, 32'h0000BEEF, 32'h0,        0, 4'b1100, 32'hBEEFBEEF, 32'h0000FFFF};
    vecs[8] = '{1'b0, 3'd3, 32'h04, 32'h0,        32'hCAFEF00D, 1, 4'b1111, 32'h0, 32'hCAFEF00D};

    rst_ni = 1'b0; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = '0;
    core_addr_i = '0; core_wd_i = '0; mem_rd_i = '0; mem_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req",  {31'b0, mem_req_o}, 32'd0);
    chk("rst_we",   {31'b0, mem_we_o}, 32'd0);
    chk("rst_be",   {28'b0, mem_be_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wd",   mem_wd_o, 32'd0);
    chk("rst_rd",   core_rd_o, 32'd0);
    chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
    chk("rst_stall_lo", {31'b0, core_stall_o}, 32'd0);
    core_req_i = 1'b1;
    #1 chk("rst_stall_follows_req", {31'b0, core_stall_o}, 32'd1);
    core_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Directed table, issued back-to-back with core_req_i held high.
    for (int i = 0; i < 9; i++)
      access(vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wd, vecs[i].mrd, vecs[i].delay,
             vecs[i].be, vecs[i].ewd, vecs[i].erd);
    last_rd = vecs[8].erd;

    // Dropping req in the IDLE after DONE must not start a duplicate access.
    core_req_i = 1'b0;
    #1;
    chk("no_dup_stall", {31'b0, core_stall_o}, 32'd0);
    chk("no_dup_req", {31'b0, mem_req_o}, 32'd0);

    // mem_ready_i outside BUSY is ignored.
    mem_ready_i = 1'b1; mem_rd_i = 32'h55555555;
    repeat (2) @(posedge clk_i);
    #1;
    chk("stray_ready_req", {31'b0, mem_req_o}, 32'd0);
    chk("stray_ready_stall", {31'b0, core_stall_o}, 32'd0);
    chk("stray_ready_rd", core_rd_o, last_rd);
    mem_ready_i = 1'b0;

`ifdef LSU_MISALIGN_CHECK_EN
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h2;
    #1 chk("mis_idle_stall", {31'b0, core_stall_o}, 32'd1);
    @(posedge clk_i); #1;
    chk("mis_req", {31'b0, mem_req_o}, 32'd0);
    chk("mis_flag", {31'b0, misalign_o}, 32'd1);
    chk("mis_rd", core_rd_o, 32'd0);
    chk("mis_stall", {31'b0, core_stall_o}, 32'd0);
    core_req_i = 1'b0;
    @(posedge clk_i); #1;
    chk("mis_flag_clear", {31'b0, misalign_o}, 32'd0);
    chk("mis_idle_req", {31'b0, mem_req_o}, 32'd0);
    last_rd = 32'd0;
`else
    // Without the check, a misaligned word proceeds with full enables and a pass-through word.
    access(1'b0, 3'd2, 32'h2, 32'h0, 32'h11223344, 0, 4'b1111, 32'h0, 32'h11223344);
    core_req_i = 1'b0;
    last_rd = 32'h11223344;
`endif

    // Reset asserted in BUSY abandons the access with no DONE.
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h40;
    @(posedge clk_i); #1;
    chk("rb_busy_req", {31'b0, mem_req_o}, 32'd1);
    core_req_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rb_req_drop", {31'b0, mem_req_o}, 32'd0);
    chk("rb_stall", {31'b0, core_stall_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    mem_ready_i = 1'b1; mem_rd_i = 32'h99999999;
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    chk("rb_no_done_rd", core_rd_o, 32'd0);
    chk("rb_idle_req", {31'b0, mem_req_o}, 32'd0);
    chk("rb_idle_stall", {31'b0, core_stall_o}, 32'd0);
    last_rd = 32'd0;

    // Randomized accesses against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic [2:0]  sz;
      logic [31:0] addr, wd, mrd, erd;
      int unsigned dly;
      we   = 1'($urandom_range(0, 1));
      sz   = 3'($urandom_range(0, 7));
      addr = $urandom;
`ifdef LSU_MISALIGN_CHECK_EN
      addr = addr - (addr % m_bytes(sz));
`endif
      wd   = $urandom;
      mrd  = $urandom;
      dly  = $urandom_range(0, 3);
      erd  = we ? last_rd : m_rd(sz, addr, mrd);
      access(we, sz, addr, wd, mrd, dly, m_be(sz, addr), m_wd(sz, wd), erd);
      last_rd = erd;
      if ($urandom_range(0, 1) == 0) begin
        core_req_i = 1'b0;
        @(posedge clk_i); #1;
      end
    end
    core_req_i = 1'b0;
    @(posedge clk_i); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
